apb_wait_regfile: RTL and testbench



---
 rtl/apb_wait_regfile_pkg.sv | 21 ++
 rtl/apb_wait_regfile_cnt.sv | 34 +++
 rtl/apb_wait_regfile.sv | 152 +++++++++++++++
 tb/tb_apb_wait_regfile.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/apb_wait_regfile_pkg.sv
// Shared types and helpers for the APB wait-state register file.
package apb_wait_regfile_pkg;

   // Low address bits that form the byte offset within a word.
   localparam int unsigned WORD_OFFSET = 2;

   typedef enum logic [0:0] {
      StIdle,
      StAccess
   } state_e;

   function automatic int unsigned idx_width(input int unsigned num_regs);
      return $clog2(num_regs);
   endfunction

   // The wait-state register always sits in the last slot.
   function automatic int unsigned wait_idx(input int unsigned num_regs);
      return num_regs - 1;
   endfunction

endpackage

// File: rtl/apb_wait_regfile_cnt.sv
// Loadable down-counter with zero flag; holds at zero.
module apb_wait_regfile_cnt #(
   parameter int unsigned WAIT_W = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load_i,
   input  logic [WAIT_W-1:0] load_val_i,
   input  logic              dec_i,
   output logic              zero_o
);

   logic [WAIT_W-1:0] count_q, count_d;

   always_comb begin
      count_d = count_q;
      if (load_i) begin
         count_d = load_val_i;
      end else if (dec_i && (count_q != '0)) begin
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign zero_o = (count_q == '0);

endmodule

// File: rtl/apb_wait_regfile.sv
// APB completer with NUM_REGS word registers; the last one sets access wait states.
// Optional byte-strobe support via the APB_WAIT_REGFILE_PSTRB_EN macro.
module apb_wait_regfile
   import apb_wait_regfile_pkg::*;
#(
   parameter int unsigned APB_DATA_WIDTH = 32,
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned NUM_REGS       = 8,
   parameter int unsigned WAIT_W         = 4,
   parameter int unsigned DEFAULT_WAIT   = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [APB_ADDR_WIDTH-1:0]   PADDR_i,
   input  logic [APB_DATA_WIDTH-1:0]   PWDATA_i,
   input  logic                        PWRITE_i,
   input  logic                        PSEL_i,
   input  logic                        PENABLE_i,
`ifdef APB_WAIT_REGFILE_PSTRB_EN
   input  logic [APB_DATA_WIDTH/8-1:0] PSTRB_i,
`endif
   output logic [APB_DATA_WIDTH-1:0]   PRDATA_o,
   output logic                        PREADY_o,
   output logic                        PSLVERR_o
);

   localparam int unsigned IDX_W    = idx_width(NUM_REGS);
   localparam int unsigned WAIT_IDX = wait_idx(NUM_REGS);
   localparam int unsigned STRB_W   = APB_DATA_WIDTH / 8;

   state_e                    state_q, state_d;
   logic [IDX_W-1:0]          idx_q, idx_d;
   logic                      err_q, err_d;
   logic                      write_q, write_d;
   logic [APB_DATA_WIDTH-1:0] regs_q [NUM_REGS-1];
   logic [WAIT_W-1:0]         wait_q;

   logic [IDX_W-1:0]          addr_idx;
   logic                      addr_err;
   logic                      setup, xfer, commit, dec, cnt_zero;
   logic [APB_DATA_WIDTH-1:0] rd_word, wmask, new_word;

   assign addr_idx = PADDR_i[WORD_OFFSET +: IDX_W];
   assign addr_err = (PADDR_i[WORD_OFFSET-1:0] != '0) ||
                     ((PADDR_i >> (WORD_OFFSET + IDX_W)) != '0);

   assign setup    = (state_q == StIdle) && PSEL_i && !PENABLE_i;
   assign xfer     = PSEL_i && PENABLE_i;
   assign PREADY_o = (state_q == StAccess) && cnt_zero;
   assign dec      = (state_q == StAccess) && !cnt_zero && xfer;
   assign commit   = PREADY_o && xfer && write_q && !err_q;

   apb_wait_regfile_cnt #(
      .WAIT_W (WAIT_W)
   ) u_cnt (
      .clk_i      (clk),
      .rst_i      (rst),
      .load_i     (setup),
      .load_val_i (wait_q),
      .dec_i      (dec),
      .zero_o     (cnt_zero)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      err_d   = err_q;
      write_d = write_q;
      unique case (state_q)
         StIdle: begin
            // An access phase without a preceding setup is ignored.
            if (setup) begin
               idx_d   = addr_idx;
               err_d   = addr_err;
               write_d = PWRITE_i;
               state_d = StAccess;
            end
         end
         StAccess: begin
            if (!PSEL_i) begin
               state_d = StIdle;
            end else if (PREADY_o && PENABLE_i) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         idx_q   <= '0;
         err_q   <= 1'b0;
         write_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         err_q   <= err_d;
         write_q <= write_d;
      end
   end

   always_comb begin
      rd_word = '0;
      if (idx_q == IDX_W'(WAIT_IDX)) begin
         rd_word = APB_DATA_WIDTH'(wait_q);
      end else begin
         for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
            if (idx_q == IDX_W'(i)) begin
               rd_word = regs_q[i];
            end
         end
      end
   end

   always_comb begin
      wmask = '0;
`ifdef APB_WAIT_REGFILE_PSTRB_EN
      for (int unsigned b = 0; b < STRB_W; b++) begin
         wmask[b*8 +: 8] = {8{PSTRB_i[b]}};
      end
`else
      wmask = '1;
`endif
   end

   assign new_word = (rd_word & ~wmask) | (PWDATA_i & wmask);

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
            regs_q[i] <= '0;
         end
         wait_q <= WAIT_W'(DEFAULT_WAIT);
      end else if (commit) begin
         // Only the low WAIT_W bits of the wait register are stored.
         if (idx_q == IDX_W'(WAIT_IDX)) begin
            wait_q <= new_word[WAIT_W-1:0];
         end
         for (int unsigned i = 0; i < NUM_REGS - 1; i++) begin
            if (idx_q == IDX_W'(i)) begin
               regs_q[i] <= new_word;
            end
         end
      end
   end

   assign PRDATA_o  = (PREADY_o && !write_q && !err_q) ? rd_word : '0;
   assign PSLVERR_o = PREADY_o && err_q;

endmodule

// File: tb/tb_apb_wait_regfile.sv
// Directed table-driven bench for apb_wait_regfile plus abort/reset corner sequences.
module tb_apb_wait_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] paddr, pwdata, prdata;
   logic        pwrite, psel, penable, pready, pslverr;
   logic [3:0]  pstrb;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   apb_wait_regfile u_dut (
      .clk       (clk),
      .rst       (rst),
      .PADDR_i   (paddr),
      .PWDATA_i  (pwdata),
      .PWRITE_i  (pwrite),
      .PSEL_i    (psel),
      .PENABLE_i (penable),
`ifdef APB_WAIT_REGFILE_PSTRB_EN
      .PSTRB_i   (pstrb),
`endif
      .PRDATA_o  (prdata),
      .PREADY_o  (pready),
      .PSLVERR_o (pslverr)
   );

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        err;
      int          waits;
   } vec_t;

   vec_t vecs[18];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge after the completing edge.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output logic err, output int waits);
      psel    = 1'b1;
      penable = 1'b0;
      pwrite  = wr;
      paddr   = addr;
      pwdata  = wdata;
      @(negedge clk);
      penable = 1'b1;
      waits   = 0;
      while (!pready && waits < 40) begin
         @(negedge clk);
         waits++;
      end
      rdata = prdata;
      err   = pslverr;
      @(negedge clk);
      psel    = 1'b0;
      penable = 1'b0;
   endtask

   task automatic run_vec(input string name, input vec_t v);
      logic [31:0] rd;
      logic        er;
      int          w;
      xfer(v.wr, v.addr, v.wdata, rd, er, w);
      check({name, ".rdata"}, rd, v.rdata);
      check({name, ".err"}, 32'(er), 32'(v.err));
      check({name, ".waits"}, 32'(w), 32'(v.waits));
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      int          w;

      vecs[0]  = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0, 0};
      vecs[1]  = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0, 0};
      vecs[2]  = '{1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
      vecs[3]  = '{1'b1, 32'h0000_001C, 32'h0000_0003, 32'h0000_0000, 1'b0, 0};
      vecs[4]  = '{1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0, 3};
      vecs[5]  = '{1'b0, 32'h0000_001C, 32'h0,         32'h0000_0003, 1'b0, 3};
      vecs[6]  = '{1'b0, 32'h0000_0020, 32'h0,         32'h0000_0000, 1'b1, 3};
      vecs[7]  = '{1'b0, 32'h0000_0006, 32'h0,         32'h0000_0000, 1'b1, 3};
      vecs[8]  = '{1'b1, 32'h0000_0020, 32'h1234_5678, 32'h0000_0000, 1'b1, 3};
      vecs[9]  = '{1'b0, 32'h8000_0004, 32'h0,         32'h0000_0000, 1'b1, 3};
      vecs[10] = '{1'b1, 32'h0000_0010, 32'hCAFE_F00D, 32'h0000_0000, 1'b0, 3};
      vecs[11] = '{1'b1, 32'h0000_001C, 32'hFFFF_FFF0, 32'h0000_0000, 1'b0, 3};
      vecs[12] = '{1'b0, 32'h0000_001C, 32'h0,         32'h0000_0000, 1'b0, 0};
      vecs[13] = '{1'b0, 32'h0000_0010, 32'h0,         32'hCAFE_F00D, 1'b0, 0};
      vecs[14] = '{1'b0, 32'h0000_0004, 32'h0,         32'hDEAD_BEEF, 1'b0, 0};
      vecs[15] = '{1'b0, 32'h0000_0000, 32'h0,         32'h0000_0000, 1'b0, 0};
      vecs[16] = '{1'b1, 32'h0000_001C, 32'h0000_00A5, 32'h0000_0000, 1'b0, 0};
      vecs[17] = '{1'b0, 32'h0000_001C, 32'h0,         32'h0000_0005, 1'b0, 5};

      rst = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = 4'hF;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("reset.pready", 32'(pready), 32'h0);
      check("reset.prdata", prdata, 32'h0);
      check("reset.pslverr", 32'(pslverr), 32'h0);

      // Back-to-back: each transfer's setup follows the previous completion directly.
      for (int i = 0; i < 18; i++) begin
         run_vec($sformatf("vec%0d", i), vecs[i]);
      end

      // wait=5 now; seed reg 0x8, then abort a write to it in the 2nd access cycle.
      xfer(1'b1, 32'h8, 32'h0102_0304, rd, er, w);
      check("seed8.waits", 32'(w), 32'd5);
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h8; pwdata = 32'h0000_0BAD;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      check("abort.pready_idle", 32'(pready), 32'h0);
      // Access phase without setup while idle must be ignored.
      psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 32'h8;
      @(negedge clk);
      check("nosetup.pready1", 32'(pready), 32'h0);
      @(negedge clk);
      check("nosetup.pready2", 32'(pready), 32'h0);
      psel = 1'b0; penable = 1'b0;
      @(negedge clk);
      xfer(1'b0, 32'h8, 32'h0, rd, er, w);
      check("abort.reg8", rd, 32'h0102_0304);
      check("abort.waits", 32'(w), 32'd5);

      // Reset asserted in the 2nd access cycle of a write.
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h0; pwdata = 32'h0000_0055;
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      check("rstmid.pready", 32'(pready), 32'h0);
      check("rstmid.prdata", prdata, 32'h0);
      xfer(1'b0, 32'h0, 32'h0, rd, er, w);
      check("rstmid.reg0", rd, 32'h0);
      check("rstmid.waits", 32'(w), 32'd0);
      xfer(1'b0, 32'h4, 32'h0, rd, er, w);
      check("rstmid.reg4", rd, 32'h0);
      xfer(1'b0, 32'h8, 32'h0, rd, er, w);
      check("rstmid.reg8", rd, 32'h0);
      xfer(1'b0, 32'h10, 32'h0, rd, er, w);
      check("rstmid.reg10", rd, 32'h0);
      xfer(1'b0, 32'h1C, 32'h0, rd, er, w);
      check("rstmid.wait", rd, 32'h0);

`ifdef APB_WAIT_REGFILE_PSTRB_EN
      pstrb = 4'hF;
      xfer(1'b1, 32'hC, 32'h1122_3344, rd, er, w);
      pstrb = 4'b0101;
      xfer(1'b1, 32'hC, 32'hAABB_CCDD, rd, er, w);
      check("strb.err", 32'(er), 32'h0);
      pstrb = 4'b0000;
      xfer(1'b1, 32'hC, 32'hFFFF_FFFF, rd, er, w);
      check("strb0.err", 32'(er), 32'h0);
      pstrb = 4'hF;
      xfer(1'b0, 32'hC, 32'h0, rd, er, w);
      check("strb.readback", rd, 32'h11BB_33DD);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
